// File: rtl/alu_seq_if.sv
// alu_seq handshake bundle: operation request in, registered result out.
// master drives requests, slave (the ALU) returns result and status.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic [4:0]       flags;
  logic             busy;

  modport master (
    output in_valid,
    output opcode,
    output a,
    output b,
    input  in_ready,
    input  result,
    input  out_valid,
    input  flags,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  opcode,
    input  a,
    input  b,
    output in_ready,
    output result,
    output out_valid,
    output flags,
    output busy
  );
endinterface

// File: rtl/alu_seq.sv
// Registered handshaked ALU with stored status flags {C,L,F,Z,N}.
// Single-cycle ops complete in one edge; MUL is a shift-add loop.
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave s
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] W_L = WIDTH'(WIDTH);
  localparam logic [CW-1:0]    C_W = CW'(WIDTH);
  localparam logic [CW-1:0]    C_1 = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_up;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_res;
  logic [4:0]       r_flags;
  logic             r_ov;

  logic w_rdy;
  logic w_busy;
  logic w_acc;

  logic w_add;
  logic w_addu;
  logic w_addc;
  logic w_addcu;
  logic w_sub;
  logic w_cmp;
  logic w_and;
  logic w_or;
  logic w_xor;
  logic w_not;
  logic w_lsh;
  logic w_rsh;
  logic w_arsh;
  logic w_mul;

  logic             w_cin;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_aovf;
  logic             w_sovf;
  logic             w_big;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_lsv;
  logic [WIDTH-1:0] w_rsv;
  logic [WIDTH-1:0] w_asv;
  logic [WIDTH-1:0] w_res;
  logic [4:0]       w_flg;

  assign w_add   = s.opcode == 5'b00101;
  assign w_addu  = s.opcode == 5'b00110;
  assign w_addc  = s.opcode == 5'b00111;
  assign w_addcu = s.opcode == 5'b01111;
  assign w_sub   = s.opcode == 5'b01001;
  assign w_cmp   = s.opcode == 5'b01011;
  assign w_and   = s.opcode == 5'b00001;
  assign w_or    = s.opcode == 5'b00010;
  assign w_xor   = s.opcode == 5'b00011;
  assign w_not   = s.opcode == 5'b00100;
  assign w_lsh   = s.opcode == 5'b01100;
  assign w_rsh   = s.opcode == 5'b10011;
  assign w_arsh  = s.opcode == 5'b10111;
  assign w_mul   = s.opcode == 5'b01110;

  // Ready only once out of reset and while no multiply is in flight.
  assign w_rdy  = r_up && (r_state == IDLE);
  assign w_busy = r_state != IDLE;
  assign w_acc  = s.in_valid && w_rdy;

  assign s.in_ready  = w_rdy;
  assign s.busy      = w_busy;
  assign s.result    = r_res;
  assign s.flags     = r_flags;
  assign s.out_valid = r_ov;

  assign w_cin  = (w_addc | w_addcu) & r_flags[4];
  assign w_sum  = {1'b0, s.a} + {1'b0, s.b}
                + {{WIDTH{1'b0}}, w_cin};
  assign w_diff = s.a - s.b;
  assign w_aovf = (s.a[M] == s.b[M])
               && (w_sum[M] != s.a[M]);
  assign w_sovf = ((s.a[M] ^ s.b[M])
               & (s.a[M] ^ w_diff[M]));

  // Shift counts use all of b; anything past WIDTH saturates.
  assign w_big = s.b >= W_L;
  assign w_sh  = s.b[SHW-1:0];
  assign w_lsv = w_big ? '0 : (s.a << w_sh);
  assign w_rsv = w_big ? '0 : (s.a >> w_sh);
  assign w_asv = w_big ? {WIDTH{s.a[M]}}
               : WIDTH'($signed(s.a) >>> w_sh);

  // Single-cycle result and next flags from inputs and stored flags.
  always_comb begin
    w_res = '0;
    w_flg = r_flags;
    unique case (1'b1)
      w_add, w_addc: begin
        w_res = w_sum[M:0];
        w_flg = {w_sum[WIDTH], 1'b0, w_aovf,
                 ~|w_sum[M:0], w_sum[M]};
      end
      w_addu, w_addcu: w_res = w_sum[M:0];
      w_sub: begin
        w_res = w_diff;
        w_flg = {2'b00, w_sovf, ~|w_diff, w_diff[M]};
      end
      w_cmp: begin
        w_res = '0;
        w_flg = {1'b0, s.a < s.b, 1'b0, s.a == s.b,
                 $signed(s.a) < $signed(s.b)};
      end
      w_and:  w_res = s.a & s.b;
      w_or:   w_res = s.a | s.b;
      w_xor:  w_res = s.a ^ s.b;
      w_not:  w_res = ~s.a;
      w_lsh:  w_res = w_lsv;
      w_rsh:  w_res = w_rsv;
      w_arsh: w_res = w_asv;
      default: w_res = '0;
    endcase
  end

  // in_ready comes up on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_up <= 1'b0;
    else        r_up <= 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // FSM next state: MUL runs WIDTH steps then one completion cycle.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     if (w_acc && w_mul) w_next = MUL_RUN;
      MUL_RUN:  if (r_cnt == C_1) w_next = MUL_DONE;
      MUL_DONE: w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  // Shift-add multiplier: one partial product per cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
    end else if (w_acc && w_mul) begin
      r_cnt    <= C_W;
      r_mcand  <= s.a;
      r_mplier <= s.b;
      r_acc    <= '0;
    end else if (r_state == MUL_RUN) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - C_1;
    end
  end

  // Output result, flags and completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res   <= '0;
      r_flags <= '0;
      r_ov    <= 1'b0;
    end else begin
      r_ov <= 1'b0;
      if (w_acc && !w_mul) begin
        r_res   <= w_res;
        r_flags <= w_flg;
        r_ov    <= 1'b1;
      end else if (r_state == MUL_DONE) begin
        r_res <= r_acc;
        r_ov  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, handshaked, parametrised-width successor to the team's combinational 16-bit ALU. It keeps the same 5-bit opcode set and the same 5-bit flag layout. Flags live in an internal processor-status register that only flag-setting ops modify, so ADDC/ADDCU chain through the stored carry. A multi-cycle shift-add MUL is added. The block sits between the register-file read stage and write-back in the datapath.

## Interface

Parameters:
- `WIDTH`, default 16, operand/result width; legal range 4–64.
- `SHW`, default `$clog2(WIDTH)+1`, width of the shift-count field taken from `b`.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous and active-low.
- `in_valid` in 1 — an operation is presented.
- `in_ready` out 1 — block can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `opcode` in 5 — operation select.
- `a` in `WIDTH` — operand A.
- `b` in `WIDTH` — operand B; for shifts, the full value is the shift count.
- `result` out `WIDTH` — registered result.
- `out_valid` out 1 — one-cycle pulse: `result` and `flags` are updated for the completed op.
- `flags` out 5 — status register `{C, L, F, Z, N}` = bits `[4:0]`.
- `busy` out 1 — MUL in progress.

## Operation

Opcodes:
- ADD `00101`, ADDU `00110`, ADDC `00111`, ADDCU `01111`, SUB `01001`, CMP `01011`.
- AND `00001`, OR `00010`, XOR `00011`, NOT `00100`.
- LSH `01100`, RSH `10011`, ARSH `10111`, MUL `01110`.

Flag-setting ops (ADD, ADDC, SUB, CMP) overwrite all five flags:
- ADD/ADDC: C = carry-out of the `WIDTH`-bit sum; ADDC adds the stored `flags[4]`. F = signed overflow (operands same sign, result sign differs). Z = result==0. N = result MSB. L = 0.
- SUB: result = a−b. F = `(a^b)&(a^result)` on the MSB. Z and N as for ADD. C = 0, L = 0.
- CMP: result register loads 0. Z = (a==b). N = signed a < signed b. L = unsigned a < unsigned b. C = 0, F = 0.

All other ops leave `flags` unchanged:
- ADDCU: result = a + b + stored C.
- ADDU: result = a + b.
- AND, OR, XOR: bitwise on a and b. NOT: result = ~a.
- Shift counts use the full `b` value:
  - LSH/RSH: count ≥ `WIDTH` gives 0.
  - ARSH: count ≥ `WIDTH` gives all bits equal to a's MSB.
- MUL: result = low `WIDTH` bits of unsigned a×b.
- Undefined opcode: result = 0, flags unchanged, `out_valid` still pulses.

State machine: IDLE, MUL_RUN, MUL_DONE.
- In IDLE, `in_ready` = 1.
- IDLE → MUL_RUN on accepting MUL. The accept edge latches multiplicand, multiplier and a zeroed accumulator, and sets counter = `WIDTH`.
- MUL_RUN: each cycle, if multiplier LSB = 1, add the multiplicand to the accumulator. Then shift the multiplicand left, shift the multiplier right, and decrement the counter. At counter = 1, go to MUL_DONE.
- MUL_DONE: load the accumulator into `result`, pulse `out_valid`, return to IDLE.
- `in_ready` = 0 and `busy` = 1 in MUL_RUN and MUL_DONE. Inputs are ignored there.

## Timing

- Reset asserted (asynchronous): `result` = 0, `flags` = 0, `out_valid` = 0, `busy` = 0, `in_ready` = 0, state = IDLE.
- `in_ready` rises on the first rising edge after `rst_n` deasserts.
- Reset mid-MUL aborts the multiply; no `out_valid` is produced.
- Single-cycle ops: result and flags are computed from the inputs and the current `flags`. They are registered on the accept edge, and `out_valid` is high for the following cycle (latency 1).
- Back-to-back single-cycle ops are accepted every cycle. An ADDC accepted at edge k+1 uses the carry written at edge k, so chains need no bubbles.
- MUL accepted at edge k: `out_valid` is high in the cycle after edge k+`WIDTH`+1. The next accept is possible at edge k+`WIDTH`+2.
- `out_valid` is low in every cycle that does not follow a completion.
- There is no output back-pressure; the consumer must sample `result` during the `out_valid` cycle.

## Test plan

All scenarios use `WIDTH`=16.
- **Reset:** hold `rst_n` low with `in_valid`=1 → all outputs 0, no accept. Release → `in_ready`=1 one edge later.
- **Flags:**
  - ADD `7FFF`+`0001` → result `8000`, flags `00101` (F, N).
  - ADD `FFFF`+`0001` → result `0000`, flags `10010` (C, Z).
  - A following AND `F0F0`&`0FF0` → result `00F0`, flags still `10010`.
- **Carry chain:** ADD `FFFF`+`0001`, then ADDC `0000`+`0000` on the next cycle → result `0001`, C = 0. With ADDCU in place of ADDC → result `0001`, flags unchanged `10010`.
- **CMP and SUB:**
  - CMP a=`FFFE`, b=`0001` → result 0, Z=0, N=1, L=0.
  - SUB `8000`−`0001` → result `7FFF`, F=1, N=0.
- **Shifts:**
  - ARSH `8000` by 3 → `F000`.
  - ARSH `8000` by 20 → `FFFF`.
  - RSH `8000` by 16 → `0000`.
  - LSH `0001` by 15 → `8000`.
- **MUL:**
  - `00FF`×`0101` → `FFFF`, `out_valid` exactly 17 cycles after accept. `in_ready` low throughout, flags unchanged.
  - Offered ops are ignored during the multiply.
  - Assert `rst_n` at cycle 8 of the multiply → no `out_valid`, `result` = 0.
